// File: rtl/pwm_duty_sequencer_if.sv
// pwm_duty_sequencer_if
//   Groups the key and period inputs with the duty outputs of the PWM duty
//   sequencer.
//   master : drives key_flag, key_press and period_tick; observes duty,
//            duty_upd and mode.
//   slave  : the sequencer side.
//   key_flag    one-cycle debounced key event strobe
//   key_press   debounced key level, 1 = pressed
//   period_tick one-cycle pulse on PWM counter wrap
//   duty        registered duty count for the PWM comparator
//   duty_upd    one-cycle pulse when duty is (re)loaded
//   mode        active mode: 0 FIX_LO, 1 FIX_HI, 2 BREATHE
interface pwm_duty_sequencer_if;
   logic        key_flag;
   logic        key_press;
   logic        period_tick;
   logic [15:0] duty;
   logic        duty_upd;
   logic [1:0]  mode;

   modport master (
      output key_flag,
      output key_press,
      output period_tick,
      input  duty,
      input  duty_upd,
      input  mode
   );

   modport slave (
      input  key_flag,
      input  key_press,
      input  period_tick,
      output duty,
      output duty_upd,
      output mode
   );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer
//   Key-driven PWM duty sequencer. Each key press advances a pending mode
//   (FIX_LO -> FIX_HI -> BREATHE -> FIX_LO); the pending mode and the new duty
//   are applied only on period_tick, so the comparator never sees a duty change
//   mid-period. BREATHE ramps duty between DUTY_MIN and DUTY_MAX by STEP per
//   PWM period.
//   Optional feature macro: PWM_SEQ_DWELL_EN -- hold at each ramp extreme for
//   DWELL extra periods before reversing.
// Ports
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   io         pwm_duty_sequencer_if.slave (key/tick inputs, duty/mode outputs)
//
// state        | meaning
// -------------+-----------------------------------------------
// MODE_FIX_LO  | duty fixed at DUTY_LO
// MODE_FIX_HI  | duty fixed at DUTY_HI
// MODE_BREATHE | duty ramps DUTY_MIN <-> DUTY_MAX by STEP/period
module pwm_duty_sequencer #(
   parameter logic [15:0] DUTY_LO  = 16'd10000,
   parameter logic [15:0] DUTY_HI  = 16'd40000,
   parameter logic [15:0] DUTY_MIN = 16'd0,
   parameter logic [15:0] DUTY_MAX = 16'd50000,
   parameter logic [15:0] STEP     = 16'd500,
   parameter logic [3:0]  DWELL    = 4'd8
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   pwm_duty_sequencer_if.slave  io
);

   typedef enum logic [1:0] {
      MODE_FIX_LO  = 2'd0,
      MODE_FIX_HI  = 2'd1,
      MODE_BREATHE = 2'd2
   } mode_e;

   if (DUTY_MIN >= DUTY_MAX || STEP == 16'd0 || $bits(DWELL) != 4) begin : g_param_err
      $error("pwm_duty_sequencer: need DUTY_MIN < DUTY_MAX, nonzero STEP, 4-bit DWELL");
   end

   mode_e       mode_q;
   mode_e       pend_q;
   mode_e       pend_next;
   logic [15:0] duty_q;
   logic        upd_q;
   logic        dir_up_q;
   logic        press;
   logic [16:0] sum_up;
   logic [16:0] floor_lim;
   logic        hit_top;
   logic        hit_bottom;

`ifdef PWM_SEQ_DWELL_EN
   logic [3:0]  dwell_q;
`endif

   function automatic mode_e advance(input mode_e m);
      case (m)
         MODE_FIX_LO:  return MODE_FIX_HI;
         MODE_FIX_HI:  return MODE_BREATHE;
         default:      return MODE_FIX_LO;
      endcase
   endfunction

   // release strobes (key_flag with key_press low) are not presses
   assign press = io.key_flag & io.key_press;

   always_comb begin
      pend_next = pend_q;
      if (press) pend_next = advance(pend_q);
   end

   // 17-bit arithmetic keeps the up-step from wrapping past 16'hFFFF and the
   // down-step compare free of borrow.
   assign sum_up     = {1'b0, duty_q} + {1'b0, STEP};
   assign floor_lim  = {1'b0, DUTY_MIN} + {1'b0, STEP};
   assign hit_top    = (sum_up >= {1'b0, DUTY_MAX});
   assign hit_bottom = ({1'b0, duty_q} <= floor_lim);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mode_q   <= MODE_FIX_LO;
         pend_q   <= MODE_FIX_LO;
         duty_q   <= DUTY_LO;
         upd_q    <= 1'b0;
         dir_up_q <= 1'b1;
`ifdef PWM_SEQ_DWELL_EN
         dwell_q  <= 4'd0;
`endif
      end else begin
         upd_q  <= io.period_tick;
         pend_q <= pend_next;
         if (io.period_tick) begin
            // a press coinciding with the tick is already folded into pend_next
            mode_q <= pend_next;
            case (pend_next)
               MODE_FIX_HI: begin
                  duty_q   <= DUTY_HI;
                  dir_up_q <= 1'b1;
`ifdef PWM_SEQ_DWELL_EN
                  dwell_q  <= 4'd0;
`endif
               end
               MODE_BREATHE: begin
                  if (mode_q != MODE_BREATHE) begin
                     duty_q   <= DUTY_MIN;
                     dir_up_q <= 1'b1;
`ifdef PWM_SEQ_DWELL_EN
                     dwell_q  <= 4'd0;
                  end else if (dwell_q != 4'd0) begin
                     dwell_q  <= dwell_q - 4'd1;
`endif
                  end else if (dir_up_q) begin
                     if (hit_top) begin
                        duty_q   <= DUTY_MAX;
                        dir_up_q <= 1'b0;
`ifdef PWM_SEQ_DWELL_EN
                        dwell_q  <= DWELL;
`endif
                     end else begin
                        duty_q <= sum_up[15:0];
                     end
                  end else begin
                     if (hit_bottom) begin
                        duty_q   <= DUTY_MIN;
                        dir_up_q <= 1'b1;
`ifdef PWM_SEQ_DWELL_EN
                        dwell_q  <= DWELL;
`endif
                     end else begin
                        duty_q <= duty_q - STEP;
                     end
                  end
               end
               default: begin
                  duty_q   <= DUTY_LO;
                  dir_up_q <= 1'b1;
`ifdef PWM_SEQ_DWELL_EN
                  dwell_q  <= 4'd0;
`endif
               end
            endcase
         end
      end
   end

   assign io.duty     = duty_q;
   assign io.duty_upd = upd_q;
   assign io.mode     = mode_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb_pwm_duty_sequencer
//   Two sequencers (default STEP and STEP=30000) driven with identical key and
//   tick stimulus. A behavioural model pushes the expected mode/duty for every
//   tick into a per-instance queue; the entry is popped when duty_upd appears.
module tb_pwm_duty_sequencer;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;

   pwm_duty_sequencer_if io_a ();
   pwm_duty_sequencer_if io_b ();

   pwm_duty_sequencer u_a (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .io        (io_a.slave)
   );

   pwm_duty_sequencer #(.STEP(16'd30000)) u_b (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .io        (io_b.slave)
   );

   always #10 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [1:0]  mode;
      logic [15:0] duty;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int n_vec = 0;
   int n_bad = 0;

   int m_mode  [2];
   int m_pend  [2];
   int m_duty  [2];
   int m_dwell [2];
   bit m_up    [2];
   int m_step  [2] = '{500, 30000};

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, wanted %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k]  = 0;
         m_pend[k]  = 0;
         m_duty[k]  = 10000;
         m_dwell[k] = 0;
         m_up[k]    = 1'b1;
      end
      q_a.delete();
      q_b.delete();
   endtask

   task automatic model_step(input int k, input bit f, input bit p, input bit t);
      exp_t e;
      if (f && p) m_pend[k] = (m_pend[k] + 1) % 3;
      if (t) begin
         if (m_pend[k] == 0) begin
            m_duty[k] = 10000; m_up[k] = 1'b1; m_dwell[k] = 0;
         end else if (m_pend[k] == 1) begin
            m_duty[k] = 40000; m_up[k] = 1'b1; m_dwell[k] = 0;
         end else if (m_mode[k] != 2) begin
            m_duty[k] = 0; m_up[k] = 1'b1; m_dwell[k] = 0;
         end else if (m_dwell[k] > 0) begin
            m_dwell[k]--;
         end else if (m_up[k]) begin
            m_duty[k] += m_step[k];
            if (m_duty[k] >= 50000) begin
               m_duty[k] = 50000; m_up[k] = 1'b0;
`ifdef PWM_SEQ_DWELL_EN
               m_dwell[k] = 8;
`endif
            end
         end else begin
            m_duty[k] -= m_step[k];
            if (m_duty[k] <= 0) begin
               m_duty[k] = 0; m_up[k] = 1'b1;
`ifdef PWM_SEQ_DWELL_EN
               m_dwell[k] = 8;
`endif
            end
         end
         m_mode[k] = m_pend[k];
         e.mode = 2'(m_mode[k]);
         e.duty = 16'(m_duty[k]);
         if (k == 0) q_a.push_back(e);
         else        q_b.push_back(e);
      end
   endtask

   task automatic check_inst(input int k, input int mode, input int duty, input int upd);
      exp_t  e;
      bit    have;
      string pfx;
      pfx  = (k == 0) ? "a_" : "b_";
      have = 1'b0;
      if (k == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
      if (k == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
      if (have) begin
         chk({pfx, "duty_upd"},  upd,  1);
         chk({pfx, "tick_mode"}, mode, int'(e.mode));
         chk({pfx, "tick_duty"}, duty, int'(e.duty));
      end else begin
         chk({pfx, "no_upd"},    upd,  0);
         chk({pfx, "hold_duty"}, duty, m_duty[k]);
         chk({pfx, "hold_mode"}, mode, m_mode[k]);
      end
   endtask

   task automatic drive(input bit f, input bit p, input bit t);
      @(negedge sys_clk);
      check_inst(0, int'(io_a.mode), int'(io_a.duty), int'(io_a.duty_upd));
      check_inst(1, int'(io_b.mode), int'(io_b.duty), int'(io_b.duty_upd));
      io_a.key_flag = f; io_a.key_press = p; io_a.period_tick = t;
      io_b.key_flag = f; io_b.key_press = p; io_b.period_tick = t;
      model_step(0, f, p, t);
      model_step(1, f, p, t);
   endtask

   task automatic tick_period(input int len);
      drive(1'b0, 1'b0, 1'b1);
      repeat (len - 1) drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_a_mode"}, int'(io_a.mode), 0);
      chk({tag, "_a_duty"}, int'(io_a.duty), 10000);
      chk({tag, "_a_upd"},  int'(io_a.duty_upd), 0);
      chk({tag, "_b_mode"}, int'(io_b.mode), 0);
      chk({tag, "_b_duty"}, int'(io_b.duty), 10000);
   endtask

   initial begin
      io_a.key_flag = 1'b0; io_a.key_press = 1'b0; io_a.period_tick = 1'b0;
      io_b.key_flag = 1'b0; io_b.key_press = 1'b0; io_b.period_tick = 1'b0;
      model_reset();

      repeat (2) @(negedge sys_clk);
      chk_reset_state("rst");
      sys_rst_n = 1'b1;

      // FIX_LO after reset release
      repeat (3) tick_period(4);

      // press, release strobe, bare level: only the press advances pending
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      tick_period(3);

      // press coinciding with tick while in FIX_HI enters BREATHE at once
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);

      // full ramp up, down and one step back up
      repeat (201) tick_period(3);

      // two presses between ticks: BREATHE -> FIX_LO -> FIX_HI
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      tick_period(3);

      // back into BREATHE and ramp to mid-scale
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      repeat (50) tick_period(3);
      drive(1'b0, 1'b0, 1'b0);
      chk("pre_reset_duty", int'(io_a.duty), 25000);

      // asynchronous reset mid-ramp, away from any clock edge
      #3 sys_rst_n = 1'b0;
      #1 chk_reset_state("async_rst");
      model_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      repeat (3) tick_period(3);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("a_queue_drain", q_a.size(), 0);
      chk("b_queue_drain", q_b.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
